// File: rtl/sync_fifo_p_pkg.sv
// sync_fifo_p_pkg: shared constants and pointer-width helper for the parametrised FIFO.
package sync_fifo_p_pkg;

    localparam int UART_DEPTH     = 16;
    localparam int UART_AF_MARGIN = 4;
    localparam int UART_AE_THRESH = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v << 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_p_mem.sv
// sync_fifo_p_mem: DEPTH x DATA_WIDTH register array, sync write, async read, no reset.
module sync_fifo_p_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_p.sv
// sync_fifo_p: single-clock show-ahead FIFO with occupancy count, threshold flags,
// flush and sticky overflow/underflow errors.
module sync_fifo_p
    import sync_fifo_p_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = UART_DEPTH,
    parameter int AF_THRESH  = DEPTH - UART_AF_MARGIN,
    parameter int AE_THRESH  = UART_AE_THRESH,
    localparam int AW        = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [AW:0]           count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_AF   = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] CNT_AE   = (AW+1)'(AE_THRESH);

    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop, ov_evt, uf_evt;

    assign full         = count == CNT_FULL;
    assign empty        = count == '0;
    assign almost_full  = count >= CNT_AF;
    assign almost_empty = count <= CNT_AE;

    // a pop frees the head slot in the same edge, so a full FIFO still accepts push+pop
    assign do_push = ~flush & push & (~full | pop);
    assign do_pop  = ~flush & pop & ~empty;
    assign ov_evt  = ~flush & push & full & ~pop;
    assign uf_evt  = ~flush & pop & empty;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (do_push) wptr <= wptr + AW'(1);
                if (do_pop) rptr <= rptr + AW'(1);
                count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            end
            overflow  <= ov_evt | (overflow & ~clr_err);
            underflow <= uf_evt | (underflow & ~clr_err);
        end

    sync_fifo_p_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_mem (
        .clk  (clk),
        .we   (do_push),
        .waddr(wptr),
        .wdata(wdata),
        .raddr(rptr),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_sync_fifo_p.sv
// tb_sync_fifo_p: directed self-checking bench for sync_fifo_p (16 x 8 defaults).
module tb_sync_fifo_p;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0, clr_err = 1'b0, push = 1'b0, pop = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;

    sync_fifo_p #(
        .DATA_WIDTH(8),
        .DEPTH     (16),
        .AF_THRESH (12),
        .AE_THRESH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .clr_err     (clr_err),
        .push        (push),
        .wdata       (wdata),
        .pop         (pop),
        .rdata       (rdata),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
    endtask

    logic [7:0] q[$];
    logic       mfull, mempty, mp, mq;

    initial begin
        // reset state
        tick(); tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ae", 32'(almost_empty), 1);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_ov", 32'(overflow), 0);
        chk("rst_uf", 32'(underflow), 0);
        rst = 1'b0;
        tick();

        // 1: fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            push = 1'b1; wdata = 8'(i);
            tick();
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_af", 32'(almost_full), 32'(i + 1 >= 12));
            chk("fill_ae", 32'(almost_empty), 32'(i + 1 <= 4));
            chk("fill_full", 32'(full), 32'(i + 1 == 16));
            chk("fill_rdata", 32'(rdata), 0);
        end

        // 2: push+pop while full
        push = 1'b1; pop = 1'b1; wdata = 8'hAA;
        chk("pp_full_pop_val", 32'(rdata), 32'h00);
        tick();
        chk("pp_full_count", 32'(count), 16);
        chk("pp_full_full", 32'(full), 1);
        chk("pp_full_ov", 32'(overflow), 0);
        push = 1'b0;
        for (int i = 1; i < 16; i++) begin
            chk("drain_order", 32'(rdata), 32'(i));
            tick();
        end
        chk("drain_last", 32'(rdata), 32'hAA);
        chk("drain_cnt1", 32'(count), 1);
        tick();
        chk("drain_empty", 32'(empty), 1);
        chk("drain_uf", 32'(underflow), 0);
        idle();

        // 3: overflow on full, then clr_err
        for (int i = 0; i < 16; i++) begin
            push = 1'b1; wdata = 8'(8'h20 + i);
            tick();
        end
        wdata = 8'h55;
        tick();
        chk("ov_set", 32'(overflow), 1);
        chk("ov_count", 32'(count), 16);
        chk("ov_head", 32'(rdata), 32'h20);
        push = 1'b0; clr_err = 1'b1;
        tick();
        chk("ov_clr", 32'(overflow), 0);
        clr_err = 1'b0; pop = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("ov_contents", 32'(rdata), 32'(8'h20 + i));
            tick();
        end
        chk("ov_drained", 32'(empty), 1);
        idle();

        // 4: push+pop while empty
        push = 1'b1; pop = 1'b1; wdata = 8'h3C;
        tick();
        chk("pe_count", 32'(count), 1);
        chk("pe_empty", 32'(empty), 0);
        chk("pe_rdata", 32'(rdata), 32'h3C);
        chk("pe_uf", 32'(underflow), 1);
        push = 1'b0; clr_err = 1'b1;
        tick();
        chk("pe_uf_clr", 32'(underflow), 0);
        chk("pe_count0", 32'(count), 0);
        idle();

        // 5: random traffic against a queue scoreboard
        for (int c = 0; c < 40; c++) begin
            push = 1'($urandom); pop = 1'($urandom); wdata = 8'($urandom);
            if (q.size() > 0) chk("rnd_rdata", 32'(rdata), 32'(q[0]));
            mfull = q.size() == 16;
            mempty = q.size() == 0;
            mp = push & (~mfull | pop);
            mq = pop & ~mempty;
            if (mq) void'(q.pop_front());
            if (mp) q.push_back(wdata);
            tick();
            chk("rnd_count", 32'(count), 32'(q.size()));
            chk("rnd_ae", 32'(almost_empty), 32'(q.size() <= 4));
        end
        idle();

        // 6: flush and async reset
        flush = 1'b1;
        tick();
        chk("fl0_count", 32'(count), 0);
        flush = 1'b0; pop = 1'b1;
        tick();
        chk("fl_uf_set", 32'(underflow), 1);
        pop = 1'b0;
        for (int i = 0; i < 7; i++) begin
            push = 1'b1; wdata = 8'(8'h60 + i);
            tick();
        end
        chk("fl_count7", 32'(count), 7);
        chk("fl_head", 32'(rdata), 32'h60);
        flush = 1'b1; wdata = 8'h99;
        tick();
        chk("fl_count", 32'(count), 0);
        chk("fl_empty", 32'(empty), 1);
        chk("fl_uf_kept", 32'(underflow), 1);
        idle();
        tick();
        chk("fl_discard", 32'(count), 0);
        push = 1'b1; wdata = 8'h77;
        tick(); tick(); tick();
        chk("pre_rst_count", 32'(count), 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_full", 32'(full), 0);
        chk("arst_ae", 32'(almost_empty), 1);
        chk("arst_af", 32'(almost_full), 0);
        chk("arst_uf", 32'(underflow), 0);
        chk("arst_ov", 32'(overflow), 0);
        idle();
        tick();
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
